// File: rtl/bcd_pkg.sv
// Shared BCD constants, the converter FSM state type and the digit-count
// helper. Also used by the serial-number generator and status formatting.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Converter sequencing: wait for a trigger, shift BIN_W bits, publish.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bin2bcd_state_t;

  // Decimal digits needed to hold any bin_w-bit value.
  // (bin_w*3)/10+1 slightly over-estimates bin_w*log10(2), which is safe.
  function automatic int bcd_digits(input int bin_w);
    return (bin_w * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // Conditional add-3 ahead of the shift.
  always_comb begin
    if (digit_in >= BCD_DIGIT_W'(ADD3_THRESH)) begin
      digit_out = digit_in + BCD_DIGIT_W'(3);
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/ip_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Reconverts on start, after reset, or whenever bin_in differs from the
// value of the last conversion. bcd_out only ever shows a finished result.
module ip_bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [BIN_W-1:0]              bin_in,
  input  logic                          start,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          busy,
  output logic                          done,
  output logic                          valid,
  output logic                          overflow
);

  // Internal digits: enough for any BIN_W value, never fewer than presented.
  localparam int ND_MIN = bcd_digits(BIN_W);
  localparam int ND     = (ND_MIN > DIGITS) ? ND_MIN : DIGITS;
  localparam int SW     = BCD_DIGIT_W * ND;
  localparam int OW     = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  bin2bcd_state_t state_q, state_d;

  logic [BIN_W-1:0] shift_reg;
  logic [BIN_W-1:0] bin_last;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    adjusted;
  logic [CNT_W-1:0] cnt;
  logic             pending;

  logic trigger;
  logic load;
  logic step;
  logic finish;
  logic high_nz;

  // One add-3 cell per scratch digit, all evaluated in parallel.
  for (genvar g = 0; g < ND; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_in  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Any non-zero digit above the presented ones means the value didn't fit.
  always_comb begin
    high_nz = 1'b0;
    for (int k = DIGITS; k < ND; k++) begin
      high_nz = high_nz | (|scratch[k*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    trigger = start | pending | (bin_in != bin_last);
    case (state_q)
      IDLE: begin
        if (trigger) begin
          load    = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt == CNT_W'(BIN_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Conversion datapath and published status.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shift_reg <= '0;
      bin_last  <= '0;
      scratch   <= '0;
      cnt       <= '0;
      pending   <= 1'b1;
      bcd_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        shift_reg <= bin_in;
        bin_last  <= bin_in;
        scratch   <= '0;
        cnt       <= '0;
        pending   <= 1'b0;
        busy      <= 1'b1;
      end
      if (step) begin
        // Correct first, then shift {scratch, shift_reg} left by one.
        scratch   <= (adjusted << 1) | SW'(shift_reg[BIN_W-1]);
        shift_reg <= shift_reg << 1;
        cnt       <= cnt + CNT_W'(1);
      end
      if (finish) begin
        bcd_out  <= scratch[OW-1:0];
        overflow <= high_nz;
        valid    <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ip_bin2bcd_seq.md
Name: ip_bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It feeds the DDL serial-number generator, which adds 0x30 per digit to form ASCII. It watches its binary input (DCS IP byte, zero-extended) and reconverts automatically on any change, so the serial number follows IP reconfiguration without a separate trigger. It also reports busy, done and overflow status.

Parameters:
BIN_W, 16, width of binary input (2..32)
DIGITS, 4, number of BCD digits presented on bcd_out

Ports:
clk  in  1  system clock; all logic on rising edge
rstn  in  1  synchronous active-low reset
bin_in  in  BIN_W  binary value to convert (asynchronous to nothing; same clock domain)
start  in  1  single-cycle request to force reconversion of the current bin_in
bcd_out  out  4*DIGITS  converted result; digit k on bits [4k+3:4k], k=0 least significant
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when bcd_out/overflow update
valid  out  1  high once the first conversion after reset has completed
overflow  out  1  bin_in value of the latest conversion exceeds 10^DIGITS-1

Behaviour:
- Reset (rstn=0 at clock edge): bcd_out=0, busy=0, done=0, valid=0, overflow=0, bin_last=0, state=IDLE, pending=1. Reset wins over every other event, including mid-conversion.
- Internal digit count ND = max(DIGITS, ceil(BIN_W*log2(10)^-1)) computed as localparam (BIN_W*3)/10+1 floor-bounded by DIGITS. The scratch register is 4*ND bits.
- States: IDLE, CONV, DONE.
- IDLE: trigger = start | pending | (bin_in != bin_last). On trigger: shift_reg<=bin_in, bin_last<=bin_in, scratch<=0, cnt<=0, pending<=0, busy<=1, go CONV. Without a trigger, hold.
- CONV, once per cycle: every scratch digit >=5 gets +3 (per-digit, parallel, before the shift). Then {scratch,shift_reg} shifts left 1. cnt increments. After the shift with cnt==BIN_W-1, go DONE. Exactly BIN_W CONV cycles.
- DONE: bcd_out<=scratch low DIGITS digits; overflow<=|scratch digits DIGITS..ND-1|; done=1 for this cycle only; valid<=1; busy<=0; go IDLE.
- Latency: trigger sampled at edge 0. The result is visible on bcd_out after edge BIN_W+1. done is high during the cycle after edge BIN_W+1. Default is 17 cycles.
- bin_in/start changes during CONV/DONE are ignored. A start pulse during busy is dropped. A bin_in change is not lost: bin_last differs, so IDLE retriggers on the next cycle. bcd_out always reflects one complete, self-consistent conversion and is never partial.
- On overflow, bcd_out holds the low DIGITS decimal digits (truncation, no saturation).
- bcd_out, overflow and valid are stable between done pulses.
- Reset mid-conversion: the conversion is abandoned, outputs return to reset values, and one conversion is forced afterwards via pending.

Decomposition:
- Shared package bcd_pkg: BCD_DIGIT_W=4 constant, ADD3_THRESH=5, and a function bcd_digits(bin_w) returning the ND formula. The package is reused by the serial-number generator and by the DDL status formatting.
- One sub-module, bcd_add3_digit: combinational 4-bit in/out, adding 3 when the input is >=5. It is instantiated ND times via generate. The FSM, counter and registers stay in ip_bin2bcd_seq.

Test Plan:
- Reset release with bin_in=0 -> forced conversion; done pulses once after 17 cycles; bcd_out=0x0000, valid=1, overflow=0.
- bin_in=16'd200 (IP byte 0xC8) -> after 17 cycles bcd_out=0x0200, done one cycle, overflow=0. The downstream ASCII digits are 0x30,0x30,0x32,0x30.
- bin_in=16'd9999 -> bcd_out=0x9999, overflow=0. Then 16'd10000 -> bcd_out=0x0000, overflow=1. Then 16'd65535 -> bcd_out=0x5535, overflow=1.
- Change bin_in 123->45 on cycle 5 of a conversion -> first done gives 0x0123. busy drops for exactly one IDLE cycle, then reconversion. Second done gives 0x0045, 18 cycles after the first.
- Assert rstn=0 for one cycle mid-CONV -> busy=0, valid=0, bcd_out=0. Forced reconversion of the current bin_in completes 17 cycles after reset release.
- start pulse with unchanged bin_in=77 while IDLE -> one reconversion, done pulse, bcd_out=0x0077. start while busy -> no extra done pulse.
